// File: rtl/idstage.sv
// RV32I instruction-decode stage: register file, field decode, immediate
// generation and the pipeline register feeding execute.
module idstage #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instruction_i,
    input  logic [31:0] pc_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [2:0]  funct3_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [6:0]  funct7_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] regs_q [32];

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wb_hit;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] rs1_rd;
    logic [31:0] rs2_rd;

    logic        valid_q,   valid_d;
    logic [31:0] pc_q,      pc_d;
    logic [6:0]  opcode_q,  opcode_d;
    logic [4:0]  rd_q,      rd_d;
    logic [2:0]  funct3_q,  funct3_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [6:0]  funct7_q,  funct7_d;
    logic [31:0] rs1_dat_q, rs1_dat_d;
    logic [31:0] rs2_dat_q, rs2_dat_d;
    logic [31:0] imm_q,     imm_d;
    logic        illegal_q, illegal_d;

    assign inst   = instruction_i;
    assign opc    = inst[6:0];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign wb_hit = wb_we_i && (wb_rd_i != 5'd0);

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'b0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12],
                       inst[20], inst[30:21], 1'b0};
            OP_REG:
                imm = '0;
            default:
                illegal = 1'b1;
        endcase
    end

    // x0 reads as zero; bypass forwards a same-cycle write-back
    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if (rs1 != 5'd0) begin
            if (BYPASS && wb_hit && wb_rd_i == rs1) rs1_rd = wb_data_i;
            else rs1_rd = regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            if (BYPASS && wb_hit && wb_rd_i == rs2) rs2_rd = wb_data_i;
            else rs2_rd = regs_q[rs2];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wb_hit) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct7_d  = funct7_q;
        rs1_dat_d = rs1_dat_q;
        rs2_dat_d = rs2_dat_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (flush_i) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            opcode_d  = '0;
            rd_d      = '0;
            funct3_d  = '0;
            rs1_d     = '0;
            rs2_d     = '0;
            funct7_d  = '0;
            rs1_dat_d = '0;
            rs2_dat_d = '0;
            imm_d     = '0;
            illegal_d = 1'b0;
        end else if (stall_i) begin
            // held operands track write-back so they never go stale
            if (wb_hit && wb_rd_i == rs1_q) rs1_dat_d = wb_data_i;
            if (wb_hit && wb_rd_i == rs2_q) rs2_dat_d = wb_data_i;
        end else begin
            valid_d   = valid_i;
            pc_d      = pc_i;
            opcode_d  = opc;
            rd_d      = inst[11:7];
            funct3_d  = inst[14:12];
            rs1_d     = rs1;
            rs2_d     = rs2;
            funct7_d  = inst[31:25];
            rs1_dat_d = rs1_rd;
            rs2_dat_d = rs2_rd;
            imm_d     = imm;
            illegal_d = illegal && valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            opcode_q  <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct7_q  <= '0;
            rs1_dat_q <= '0;
            rs2_dat_q <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct7_q  <= funct7_d;
            rs1_dat_q <= rs1_dat_d;
            rs2_dat_q <= rs2_dat_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign opcode_o   = opcode_q;
    assign rd_o       = rd_q;
    assign funct3_o   = funct3_q;
    assign rs1_o      = rs1_q;
    assign rs2_o      = rs2_q;
    assign funct7_o   = funct7_q;
    assign rs1_data_o = rs1_dat_q;
    assign rs2_data_o = rs2_dat_q;
    assign imm_o      = imm_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_idstage.sv
// Table-driven bench for idstage: each row's expected output bundle is
// queued when driven and compared one cycle later.
module tb_idstage;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush, we;
    logic [31:0] instr, pc, wdata;
    logic [4:0]  wrd;
    logic        valid_o, illegal_o;
    logic [31:0] pc_o, r1d_o, r2d_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        rst, valid, stall, flush;
        logic [31:0] instr, pc;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        exp_t        e;
    } vec_t;

    vec_t tbl[17];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    idstage #(.BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .instruction_i(instr), .pc_i(pc),
        .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .wb_we_i(we), .wb_rd_i(wrd), .wb_data_i(wdata),
        .valid_o(valid_o), .pc_o(pc_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct7_o(funct7_o), .rs1_data_o(r1d_o), .rs2_data_o(r2d_o),
        .imm_o(imm_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input int row, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
        end
    endtask

    task automatic step(input int row, input vec_t t);
        exp_t e;
        rst   = t.rst;   valid = t.valid; stall = t.stall; flush = t.flush;
        instr = t.instr; pc    = t.pc;    we    = t.we;
        wrd   = t.wrd;   wdata = t.wdata;
        sb.push_back(t.e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL row %0d scoreboard: got empty expected entry", row);
        end else begin
            e = sb.pop_front();
            chk(row, "valid",   {31'b0, valid_o},   {31'b0, e.v});
            chk(row, "pc",      pc_o,               e.pc);
            chk(row, "opcode",  {25'b0, opcode_o},  {25'b0, e.op});
            chk(row, "rd",      {27'b0, rd_o},      {27'b0, e.rd});
            chk(row, "funct3",  {29'b0, funct3_o},  {29'b0, e.f3});
            chk(row, "rs1",     {27'b0, rs1_o},     {27'b0, e.rs1});
            chk(row, "rs2",     {27'b0, rs2_o},     {27'b0, e.rs2});
            chk(row, "funct7",  {25'b0, funct7_o},  {25'b0, e.f7});
            chk(row, "rs1_data", r1d_o,             e.r1d);
            chk(row, "rs2_data", r2d_o,             e.r2d);
            chk(row, "imm",     imm_o,              e.imm);
            chk(row, "illegal", {31'b0, illegal_o}, {31'b0, e.ill});
        end
    endtask

    localparam exp_t ZERO = '{1'b0, 32'h0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0,
                              7'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    localparam exp_t SW_HOLD = '{1'b1, 32'h200, 7'h23, 5'd28, 3'd2, 5'd2,
                                 5'd1, 7'h7F, 32'hCAFEF00D, 32'h0,
                                 32'hFFFFFFFC, 1'b0};

    initial begin
        exp_t h;
        rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr = '0; pc = '0; we = 1'b0; wrd = '0; wdata = '0;

        // rst valid stall flush instr pc we wrd wdata / expected
        tbl[0]  = '{1, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, ZERO};
        tbl[1]  = '{0, 1, 0, 0, 32'h00500093, 32'h100, 1, 5'd2, 32'hDEADBEEF,
                    '{1, 32'h100, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h0,
                      32'h0, 32'h0, 32'h5, 0}};
        tbl[2]  = '{0, 1, 0, 0, 32'hFE112E23, 32'h104, 0, 5'd0, 32'h0,
                    '{1, 32'h104, 7'h23, 5'd28, 3'd2, 5'd2, 5'd1, 7'h7F,
                      32'hDEADBEEF, 32'h0, 32'hFFFFFFFC, 0}};
        tbl[3]  = '{0, 1, 0, 0, 32'h00118213, 32'h108, 1, 5'd3, 32'h12345678,
                    '{1, 32'h108, 7'h13, 5'd4, 3'd0, 5'd3, 5'd1, 7'h0,
                      32'h12345678, 32'h0, 32'h1, 0}};
        tbl[4]  = '{0, 1, 0, 0, 32'h00000313, 32'h10C, 1, 5'd0, 32'hFFFFFFFF,
                    '{1, 32'h10C, 7'h13, 5'd6, 3'd0, 5'd0, 5'd0, 7'h0,
                      32'h0, 32'h0, 32'h0, 0}};
        tbl[5]  = '{0, 1, 0, 0, 32'h00000393, 32'h110, 0, 5'd0, 32'h0,
                    '{1, 32'h110, 7'h13, 5'd7, 3'd0, 5'd0, 5'd0, 7'h0,
                      32'h0, 32'h0, 32'h0, 0}};
        tbl[6]  = '{0, 1, 0, 0, 32'h123452B7, 32'h114, 0, 5'd0, 32'h0,
                    '{1, 32'h114, 7'h37, 5'd5, 3'd5, 5'd8, 5'd3, 7'h09,
                      32'h0, 32'h12345678, 32'h12345000, 0}};
        tbl[7]  = '{0, 1, 0, 0, 32'h0000007F, 32'h118, 0, 5'd0, 32'h0,
                    '{1, 32'h118, 7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0,
                      32'h0, 32'h0, 32'h0, 1}};
        tbl[8]  = '{0, 0, 0, 0, 32'h0000007F, 32'h11C, 0, 5'd0, 32'h0,
                    '{0, 32'h11C, 7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0,
                      32'h0, 32'h0, 32'h0, 0}};
        tbl[9]  = '{0, 1, 0, 0, 32'hFE112E23, 32'h200, 0, 5'd0, 32'h0,
                    '{1, 32'h200, 7'h23, 5'd28, 3'd2, 5'd2, 5'd1, 7'h7F,
                      32'hDEADBEEF, 32'h0, 32'hFFFFFFFC, 0}};
        tbl[10] = '{0, 1, 1, 0, 32'h00000093, 32'h204, 1, 5'd2, 32'hCAFEF00D,
                    SW_HOLD};
        tbl[11] = '{0, 1, 1, 0, 32'h00000093, 32'h208, 1, 5'd1, 32'h11111111,
                    '{1, 32'h200, 7'h23, 5'd28, 3'd2, 5'd2, 5'd1, 7'h7F,
                      32'hCAFEF00D, 32'h11111111, 32'hFFFFFFFC, 0}};
        tbl[12] = '{0, 1, 1, 1, 32'h00500093, 32'h20C, 0, 5'd0, 32'h0, ZERO};
        tbl[13] = '{0, 1, 0, 0, 32'hFE208CE3, 32'h300, 0, 5'd0, 32'h0,
                    '{1, 32'h300, 7'h63, 5'd25, 3'd0, 5'd1, 5'd2, 7'h7F,
                      32'h11111111, 32'hCAFEF00D, 32'hFFFFFFF8, 0}};
        tbl[14] = '{0, 1, 0, 0, 32'h001000EF, 32'h304, 0, 5'd0, 32'h0,
                    '{1, 32'h304, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd1, 7'h0,
                      32'h0, 32'h11111111, 32'h800, 0}};
        tbl[15] = '{1, 1, 1, 0, 32'hFE112E23, 32'h308, 1, 5'd2, 32'h55,
                    ZERO};
        tbl[16] = '{0, 1, 0, 0, 32'hFE112E23, 32'h400, 0, 5'd0, 32'h0,
                    '{1, 32'h400, 7'h23, 5'd28, 3'd2, 5'd2, 5'd1, 7'h7F,
                      32'h0, 32'h0, 32'hFFFFFFFC, 0}};

        @(negedge clk);
        for (int i = 0; i < 17; i++) step(i, tbl[i]);

        // stall with write-back to an unrelated register: nothing moves
        h     = tbl[16].e;
        step(100, '{0, 1, 1, 0, 32'h00000013, 32'h404, 1, 5'd7, 32'h77, h});
        // flush alone, with a write that must still commit to x2
        step(101, '{0, 1, 0, 1, 32'h0, 32'h408, 1, 5'd2, 32'hA5A5A5A5,
                    ZERO});
        h     = tbl[16].e;
        h.pc  = 32'h40C;
        h.r1d = 32'hA5A5A5A5;
        step(102, '{0, 1, 0, 0, 32'hFE112E23, 32'h40C, 0, 5'd0, 32'h0, h});

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/idstage.md
Name: idstage

Overview:
Instruction-decode stage; sits directly downstream of the fetch stage and consumes its 32-bit instruction and PC. Holds the 32x32 integer register file, decodes RV32I fields, generates the sign-extended immediate, and presents everything to the execute stage through an output pipeline register. The register file is written from the write-back port. The stage supports stall, flush and write-to-read bypass.

Parameters:
BYPASS, 1, 1 = a same-cycle write-back to a read register is forwarded into the read data; 0 = the old register value is read.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
instruction_i  in  32  instruction from fetch
pc_i  in  32  PC of instruction_i
valid_i  in  1  instruction_i/pc_i are valid
stall_i  in  1  hold the output register
flush_i  in  1  squash the output register (insert bubble)
wb_we_i  in  1  register-file write enable
wb_rd_i  in  5  write address
wb_data_i  in  32  write data
valid_o  out  1  output bundle is valid
pc_o  out  32  registered PC
opcode_o  out  7  instruction[6:0]
rd_o  out  5  instruction[11:7]
funct3_o  out  3  instruction[14:12]
rs1_o  out  5  instruction[19:15]
rs2_o  out  5  instruction[24:20]
funct7_o  out  7  instruction[31:25]
rs1_data_o  out  32  value of x[rs1]
rs2_data_o  out  32  value of x[rs2]
imm_o  out  32  sign-extended immediate
illegal_o  out  1  opcode is not in the supported set

Behaviour:
- Latency: 1 cycle. Decode and register read are combinational on instruction_i, then captured in the output register at the clock edge.
- Reset (rst_i=1 at the edge): all outputs go to 0, and all 32 registers are cleared to 0.
- Priority at each edge: rst_i > flush_i > stall_i > load.
- Flush: valid_o, illegal_o and all other outputs are cleared to 0, which is a bubble.
- Stall: all outputs hold their values, with one exception:
  - if wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals the held rs1_o, then rs1_data_o is updated to wb_data_i;
  - the same rule applies to rs2_o and rs2_data_o.
  - Held operands therefore never go stale.
- Load:
  - valid_o takes valid_i.
  - All other fields load from the current decode.
  - If valid_i=0, illegal_o is forced to 0.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Writes commit at the edge when wb_we_i=1. They are independent of stall_i and flush_i, but blocked by rst_i.
- Bypass (BYPASS=1): if wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals a read address, the read data is wb_data_i.
- Immediate generation:
  - I-type (OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011, FENCE 0001111): sext(inst[31:20]).
  - S-type (0100011): sext({inst[31:25], inst[11:7]}).
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type (LUI 0110111, AUIPC 0010111): {inst[31:12], 12'b0}.
  - J-type (JAL 1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R-type (0110011) and illegal opcodes: imm 0.
- illegal_o=1 for any opcode outside the 11 listed above. funct3 and funct7 are not checked here.
- Simultaneous stall_i and flush_i: flush wins.
- Reset mid-stall: the output register is cleared and the register file is cleared.

Test Plan:
1. Reset, then load 0x00500093 (addi x1,x0,5) with valid_i=1 -> the next cycle shows valid_o=1, opcode_o=0x13, rd_o=1, rs1_o=0, imm_o=0x00000005, rs1_data_o=0, illegal_o=0.
2. Write x2=0xDEADBEEF via the wb port, then load 0xFE112E23 (sw x1,-4(x2)) -> imm_o=0xFFFFFFFC, rs1_o=2, rs2_o=1, rs1_data_o=0xDEADBEEF.
3. Bypass: in the same cycle, wb writes x3=0x12345678 and the instruction reads rs1=x3 -> rs1_data_o=0x12345678 (BYPASS=1), or the old value 0 (BYPASS=0). Separately, a wb write to x0 with 0xFFFFFFFF, then reading x0 -> 0.
4. Load 0x123452B7 (lui x5,0x12345) -> imm_o=0x12345000, rd_o=5. Then load 0x0000007F -> illegal_o=1, imm_o=0.
5. Stall with rs1_o=2 held while wb writes x2=0xCAFEF00D -> outputs held, except rs1_data_o becomes 0xCAFEF00D.
6. Assert stall_i and flush_i together -> valid_o=0 and all outputs 0. Assert rst_i mid-stream -> outputs 0 the next cycle, and a later read of x2 returns 0.
